// File: rtl/gcode_command_sequencer.sv
// gcode_command_sequencer
// Buffers decoded G-code commands from the host in a circular queue and
// dispatches them one at a time to the printer control unit using a
// start/finish two-phase handshake. Reports progress, error count and an
// optional watchdog flag back to the host.
//
// Build option: define SEQ_TIMEOUT_EN to add a per-command watchdog that
// forces an in-flight command to retire as an error after TIMEOUT_CYCLES
// ISSUE cycles. Without it, `timeout` is tied low and ISSUE waits forever.

module gcode_command_sequencer #(
  parameter int unsigned DEPTH          = 8,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  // host side
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_type,
  input  logic signed [31:0]         in_x,
  input  logic signed [31:0]         in_y,
  input  logic signed [31:0]         in_z,
  input  logic signed [31:0]         in_e0,
  input  logic signed [31:0]         in_e1,
  input  logic                       pause,
  input  logic                       flush,
  // control unit side
  output logic                       start,
  output logic [31:0]                command_type,
  output logic signed [31:0]         command_x,
  output logic signed [31:0]         command_y,
  output logic signed [31:0]         command_z,
  output logic signed [31:0]         command_e0,
  output logic signed [31:0]         command_e1,
  input  logic                       cu_finish,
  input  logic                       cu_error,
  // status
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       done,
  output logic [15:0]                err_count,
  output logic                       timeout
);

  localparam int unsigned    AW      = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RELEASE
  } state_t;

  typedef struct packed {
    logic [31:0] ctype;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] e0;
    logic [31:0] e1;
  } cmd_t;

  state_t        state_q, state_d;
  cmd_t          mem [DEPTH];
  cmd_t          in_cmd;
  cmd_t          cmd_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q;
  logic          err_q;
  logic          push;
  logic          dispatch;
  logic          finish_seen;
  logic          retire;
  logic          wd_hit;
  logic          wd_fire;

  assign in_cmd   = {in_type, in_x, in_y, in_z, in_e0, in_e1};
  assign in_ready = (count_q < DEPTH_C);
  // A push coinciding with flush is discarded.
  assign push     = in_valid & in_ready & ~flush;

  assign count        = count_q;
  assign busy         = (state_q != S_IDLE);
  assign command_type = cmd_q.ctype;
  assign command_x    = cmd_q.x;
  assign command_y    = cmd_q.y;
  assign command_z    = cmd_q.z;
  assign command_e0   = cmd_q.e0;
  assign command_e1   = cmd_q.e1;

  // Next-state decode and one-cycle event strobes for the handshake FSM.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    dispatch    = 1'b0;
    finish_seen = 1'b0;
    retire      = 1'b0;
    wd_fire     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !pause && !flush) begin
          dispatch = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cu_finish) begin
          finish_seen = 1'b1;
          state_d     = S_RELEASE;
        end else if (wd_hit) begin
          wd_fire = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!cu_finish) begin
          retire  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Queue storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; pointers and count
    // define validity, and leaving it out of reset keeps it a plain RAM.
    if (push) mem[wr_ptr] <= in_cmd;
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + AW'(1);
      if (dispatch) rd_ptr <= rd_ptr + AW'(1);
      case ({push, dispatch})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Registered handshake outputs, latched command and error bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      start     <= 1'b0;
      done      <= 1'b0;
      err_q     <= 1'b0;
      err_count <= '0;
      cmd_q     <= '0;
    end else begin
      done <= retire;
      if (dispatch) begin
        cmd_q <= mem[rd_ptr];
        start <= 1'b1;
      end
      if (finish_seen) begin
        start <= 1'b0;
        err_q <= cu_error;
      end
      if (wd_fire) begin
        start <= 1'b0;
        err_q <= 1'b1;
      end
      if (retire && err_q && (err_count != 16'hFFFF))
        err_count <= err_count + 16'd1;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        timeout_q;

  // Fires on the TIMEOUT_CYCLES-th ISSUE cycle without a finish.
  assign wd_hit  = (wd_cnt == TIMEOUT_CYCLES - 32'd1);
  assign timeout = timeout_q;

  // Watchdog counter (restarts at each dispatch) and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (dispatch)               wd_cnt <= '0;
      else if (state_q == S_ISSUE) wd_cnt <= wd_cnt + 32'd1;
      if (wd_fire) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gcode_command_sequencer.sv
// Self-checking bench for gcode_command_sequencer: directed scenarios plus a
// randomized phase, all compared every cycle against a transaction-level
// model built on a queue of commands.
`timescale 1ns/1ps

module tb_gcode_command_sequencer;

  localparam int DEPTH = 8;
  localparam int TMO   = 20;

  typedef struct packed {
    logic [31:0] t;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] e0;
    logic [31:0] e1;
  } tcmd_t;

  logic clk;
  logic reset;
  logic in_valid, in_ready;
  logic [31:0] in_type;
  logic signed [31:0] in_x, in_y, in_z, in_e0, in_e1;
  logic pause, flush;
  logic start;
  logic [31:0] command_type;
  logic signed [31:0] command_x, command_y, command_z, command_e0, command_e1;
  logic cu_finish, cu_error;
  logic busy;
  logic [$clog2(DEPTH):0] count;
  logic done;
  logic [15:0] err_count;
  logic timeout;

  gcode_command_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(32'(TMO))) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_e0(in_e0), .in_e1(in_e1),
    .pause(pause), .flush(flush),
    .start(start), .command_type(command_type),
    .command_x(command_x), .command_y(command_y), .command_z(command_z),
    .command_e0(command_e0), .command_e1(command_e1),
    .cu_finish(cu_finish), .cu_error(cu_error),
    .busy(busy), .count(count), .done(done),
    .err_count(err_count), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of pending commands plus a coarse phase
  // (0 no command out, 1 waiting for finish, 2 waiting for finish to drop).
  tcmd_t mq[$];
  int    mst;
  bit    m_start, m_done, m_errq, m_tmo;
  int    m_err;
  int    m_wd;
  tcmd_t m_cmd;

  // Control-unit responder state.
  int cu_delay = 5;
  int rel_hold = 0;
  int cu_cnt = 0;
  int rel_cnt = 0;
  bit cu_never = 0;
  bit rand_err = 0;
  int err_on_idx = -1;
  int n_starts = 0;
  bit start_prev = 0;
  int done_seen = 0;

  task automatic model_edge();
    tcmd_t c;
    bit push_ok;
    if (reset) begin
      mq.delete();
      mst = 0; m_start = 0; m_done = 0; m_errq = 0; m_tmo = 0;
      m_err = 0; m_wd = 0; m_cmd = '0;
      return;
    end
    push_ok = in_valid && (mq.size() < DEPTH) && !flush;
    m_done = 0;
    case (mst)
      0: if (mq.size() > 0 && !pause && !flush) begin
           m_cmd = mq.pop_front();
           m_start = 1; mst = 1; m_wd = 0;
         end
      1: if (cu_finish) begin
           m_errq = cu_error; m_start = 0; mst = 2;
         end else begin
`ifdef SEQ_TIMEOUT_EN
           m_wd++;
           if (m_wd == TMO) begin
             m_tmo = 1; m_errq = 1; m_start = 0; mst = 2;
           end
`endif
         end
      2: if (!cu_finish) begin
           m_done = 1;
           if (m_errq && m_err < 16'hFFFF) m_err++;
           mst = 0;
         end
      default: ;
    endcase
    if (flush) mq.delete();
    if (push_ok) begin
      c = {in_type, in_x, in_y, in_z, in_e0, in_e1};
      mq.push_back(c);
    end
  endtask

  task automatic compare_all();
    check("start",     32'(start),     32'(m_start));
    check("done",      32'(done),      32'(m_done));
    check("busy",      32'(busy),      32'(mst != 0));
    check("count",     32'(count),     32'(mq.size()));
    check("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
    check("err_count", 32'(err_count), 32'(m_err));
    check("timeout",   32'(timeout),   32'(m_tmo));
    check("cmd_type",  command_type,   m_cmd.t);
    check("cmd_x",     command_x,      m_cmd.x);
    check("cmd_y",     command_y,      m_cmd.y);
    check("cmd_z",     command_z,      m_cmd.z);
    check("cmd_e0",    command_e0,     m_cmd.e0);
    check("cmd_e1",    command_e1,     m_cmd.e1);
    if (done === 1'b1) done_seen++;
  endtask

  task automatic cu_respond();
    if (reset) begin
      cu_finish = 0; cu_error = 0; cu_cnt = 0; rel_cnt = 0; start_prev = 0;
      return;
    end
    if (start && !start_prev) n_starts++;
    start_prev = start;
    if (start && !cu_finish) begin
      if (!cu_never && cu_cnt >= cu_delay) begin
        cu_finish = 1;
        cu_error  = (n_starts == err_on_idx) || (rand_err && $urandom_range(0, 3) == 0);
      end else cu_cnt++;
    end else if (cu_finish && !start) begin
      if (rel_cnt >= rel_hold) begin
        cu_finish = 0; cu_error = 0; rel_cnt = 0;
      end else rel_cnt++;
    end
    if (!start) cu_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    cu_respond();
  endtask

  task automatic push_cmd(input logic [31:0] t, input logic [31:0] x);
    in_valid = 1; in_type = t; in_x = x;
    in_y = $urandom; in_z = $urandom; in_e0 = $urandom; in_e1 = $urandom;
    step();
    in_valid = 0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (mst == 0 && mq.size() == 0 && !cu_finish) break;
      step();
    end
    check("drain_wait", 32'(mst == 0 && mq.size() == 0), 32'd1);
  endtask

  task automatic wait_phase(input int ph, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (mst == ph) break;
      step();
    end
    check("phase_wait", 32'(mst), 32'(ph));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    int d0, e0, hi;
    reset = 1; in_valid = 0; in_type = 0; in_x = 0; in_y = 0; in_z = 0;
    in_e0 = 0; in_e1 = 0; pause = 0; flush = 0; cu_finish = 0; cu_error = 0;
    step(); step();
    check("rst_start", 32'(start), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_cmd_x", command_x, 32'd0);
    reset = 0;
    step();

    // Three commands, finish 5 cycles after start, in order.
    d0 = done_seen;
    push_cmd(32'd1, 32'd100);
    push_cmd(32'd90, 32'd0);
    push_cmd(32'd1017, 32'd0);
    wait_phase(1, 20);
    for (int i = 0; i < 20 && mst == 1; i++) begin
      check("t1_x_held", command_x, 32'd100);
      step();
    end
    drain(200);
    check("t1_dones", 32'(done_seen - d0), 32'd3);
    check("t1_errs", 32'(err_count), 32'd0);

    // Fill past DEPTH while paused, then release.
    pause = 1;
    in_valid = 1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      in_type = 32'(200 + i); in_x = $urandom; in_y = $urandom;
      in_z = $urandom; in_e0 = $urandom; in_e1 = $urandom;
      step();
      if (i == DEPTH - 1) check("t2_full_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 0;
    check("t2_count", 32'(count), 32'(DEPTH));
    pause = 0;
    step();
    check("t2_ready_again", 32'(in_ready), 32'd1);
    check("t2_count_pop", 32'(count), 32'(DEPTH - 1));
    drain(500);

    // Error on the 2nd of 3 commands.
    e0 = m_err;
    err_on_idx = n_starts + 2;
    push_cmd(32'd28, 32'd1);
    push_cmd(32'd28, 32'd2);
    push_cmd(32'd28, 32'd3);
    drain(200);
    err_on_idx = -1;
    check("t3_err_count", 32'(err_count), 32'(e0 + 1));
    check("t3_err_is_one", 32'(err_count), 32'd1);

    // Flush during ISSUE with 4 queued.
    pause = 1;
    for (int i = 0; i < 5; i++) push_cmd(32'(300 + i), 32'(i));
    cu_delay = 10;
    pause = 0;
    d0 = done_seen;
    step();
    check("t4_count_pre", 32'(count), 32'd4);
    flush = 1;
    step();
    flush = 0;
    check("t4_count_flushed", 32'(count), 32'd0);
    check("t4_still_busy", 32'(busy), 32'd1);
    drain(100);
    check("t4_one_done", 32'(done_seen - d0), 32'd1);
    check("t4_idle", 32'(busy), 32'd0);
    cu_delay = 5;

`ifdef SEQ_TIMEOUT_EN
    // Control unit never finishes the first command.
    e0 = m_err;
    d0 = done_seen;
    cu_never = 1;
    push_cmd(32'd4, 32'd7);
    push_cmd(32'd5, 32'd8);
    hi = 0;
    while (start === 1'b1 && hi < 100) begin
      hi++;
      step();
    end
    cu_never = 0;
    check("t5_start_cycles", 32'(hi + 1), 32'(TMO));
    check("t5_timeout", 32'(timeout), 32'd1);
    drain(200);
    check("t5_err_count", 32'(err_count), 32'(e0 + 1));
    check("t5_dones", 32'(done_seen - d0), 32'd2);
`else
    hi = 0;
    check("t5_no_timeout", 32'(timeout), 32'(hi));
`endif

    // Randomized traffic.
    rand_err = 1;
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      in_type = $urandom; in_x = $urandom; in_y = $urandom;
      in_z = $urandom; in_e0 = $urandom; in_e1 = $urandom;
      pause = ($urandom_range(0, 9) == 0);
      flush = (mst != 0) && ($urandom_range(0, 60) == 0);
      if (!start) cu_delay = $urandom_range(0, 6);
      if (!cu_finish) rel_hold = $urandom_range(0, 3);
      step();
    end
    in_valid = 0; pause = 0; flush = 0; rand_err = 0;
    rel_hold = 0; cu_delay = 2;
    drain(1000);

    // Reset during RELEASE with two queued.
    rel_hold = 4;
    pause = 1;
    for (int i = 0; i < 3; i++) push_cmd(32'(400 + i), 32'(i));
    pause = 0;
    wait_phase(2, 50);
    check("t6_count_pre", 32'(count), 32'd2);
    reset = 1;
    step();
    reset = 0;
    check("t6_start", 32'(start), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_count", 32'(count), 32'd0);
    check("t6_err", 32'(err_count), 32'd0);
    rel_hold = 0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
